// File: rtl/mostra_sequencia.sv
// Playback side of the memory game: walks ROM addresses 0..limit, showing each word
// on the LEDs for T_ON cycles followed by T_OFF blank cycles, then pulses pronto.
module mostra_sequencia #(
    parameter int unsigned T_ON    = 500,
    parameter int unsigned T_OFF   = 250,
    parameter int unsigned TIMER_W = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
    input  logic [3:0] dado,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam logic [3:0] INICIAL = 4'd0;
    localparam logic [3:0] BUSCA   = 4'd1;
    localparam logic [3:0] CARREGA = 4'd2;
    localparam logic [3:0] LIGA    = 4'd3;
    localparam logic [3:0] DESLIGA = 4'd4;
    localparam logic [3:0] PROXIMO = 4'd5;
    localparam logic [3:0] FIM     = 4'd6;

    localparam logic [TIMER_W-1:0] TON_LAST  = TIMER_W'(T_ON - 1);
    localparam logic [TIMER_W-1:0] TOFF_LAST = TIMER_W'(T_OFF - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

    logic [3:0]         estado_q, estado_d;
    logic [3:0]         endereco_q, endereco_d;
    logic [3:0]         palavra_q, palavra_d;
    logic [3:0]         limite_q, limite_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    always_comb begin
        estado_d   = estado_q;
        endereco_d = endereco_q;
        palavra_d  = palavra_q;
        limite_d   = limite_q;
        timer_d    = timer_q;
        case (estado_q)
            INICIAL: begin
                if (iniciar) begin
                    limite_d   = limite;
                    endereco_d = 4'd0;
                    estado_d   = BUSCA;
                end
            end
            BUSCA: estado_d = CARREGA;
            CARREGA: begin
                // Registered ROM: dado reflects the address presented during BUSCA.
                palavra_d = dado;
                timer_d   = '0;
                estado_d  = LIGA;
            end
            LIGA: begin
                if (timer_q == TON_LAST) begin
                    timer_d  = '0;
                    estado_d = DESLIGA;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            DESLIGA: begin
                if (timer_q == TOFF_LAST) begin
                    timer_d  = '0;
                    estado_d = PROXIMO;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            PROXIMO: begin
                if (endereco_q == limite_q) begin
                    estado_d = FIM;
                end else begin
                    endereco_d = endereco_q + 4'd1;
                    estado_d   = BUSCA;
                end
            end
            FIM:     estado_d = INICIAL;
            default: estado_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= INICIAL;
            endereco_q <= 4'd0;
            palavra_q  <= 4'd0;
            limite_q   <= 4'd0;
            timer_q    <= '0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            palavra_q  <= palavra_d;
            limite_q   <= limite_d;
            timer_q    <= timer_d;
        end
    end

    assign endereco  = endereco_q;
    assign leds      = (estado_q == LIGA) ? palavra_q : 4'd0;
    assign ocupado   = (estado_q != INICIAL);
    assign pronto    = (estado_q == FIM);
    assign db_estado = estado_q;

endmodule

// File: tb/tb_mostra_sequencia.sv
// Directed bench for mostra_sequencia with T_ON=3, T_OFF=2 and a registered 16x4 ROM model.
module tb_mostra_sequencia;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [3:0] limite;
    logic [3:0] dado;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    logic [3:0] rom [16];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  lim;
        logic [63:0] img;
        int          ini_cyc;
        int          lim_cyc;
    } run_t;

    mostra_sequencia #(
        .T_ON   (3),
        .T_OFF  (2),
        .TIMER_W(4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .iniciar  (iniciar),
        .limite   (limite),
        .dado     (dado),
        .endereco (endereco),
        .leds     (leds),
        .ocupado  (ocupado),
        .pronto   (pronto),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) dado <= rom[endereco];

    task automatic check(input string name, input int c, input logic [3:0] act,
                         input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h required %h", name, c, act, exp);
        end
    endtask

    // Closed-form expectation: each word takes 8 cycles (BUSCA, CARREGA, 3 LIGA, 2 DESLIGA,
    // PROXIMO) starting at cycle 1; FIM follows the last word, then INICIAL.
    task automatic expect_cycle(input int c, input int lim, input logic [63:0] img);
        int w;
        int k;
        logic [3:0] st, ld, ad;
        if (c <= 8 * (lim + 1)) begin
            w  = (c - 1) / 8;
            k  = (c - 1) % 8;
            ad = 4'(w);
            if (k == 0)      st = 4'd1;
            else if (k == 1) st = 4'd2;
            else if (k <= 4) st = 4'd3;
            else if (k <= 6) st = 4'd4;
            else             st = 4'd5;
            ld = (st == 4'd3) ? img[4*w +: 4] : 4'd0;
        end else begin
            st = (c == 8 * (lim + 1) + 1) ? 4'd6 : 4'd0;
            ad = 4'(lim);
            ld = 4'd0;
        end
        check("db_estado", c, db_estado, st);
        check("leds", c, leds, ld);
        check("endereco", c, endereco, ad);
        check("ocupado", c, {3'b0, ocupado}, {3'b0, st != 4'd0});
        check("pronto", c, {3'b0, pronto}, {3'b0, st == 4'd6});
    endtask

    task automatic load_rom(input logic [63:0] img);
        for (int i = 0; i < 16; i++) rom[i] = img[4*i +: 4];
    endtask

    task automatic start(input logic [3:0] lim);
        @(negedge clock);
        limite  = lim;
        iniciar = 1'b1;
        @(posedge clock);
        #1 iniciar = 1'b0;
    endtask

    task automatic do_run(input run_t r);
        int n;
        load_rom(r.img);
        start(r.lim);
        n = 8 * (int'(r.lim) + 1) + 2;
        for (int c = 1; c <= n; c++) begin
            @(negedge clock);
            expect_cycle(c, int'(r.lim), r.img);
            iniciar = (c == r.ini_cyc && c < n);
            limite  = (r.lim_cyc != 0 && c >= r.lim_cyc) ? 4'd0 : r.lim;
        end
        iniciar = 1'b0;
    endtask

    run_t runs [4];

    initial begin
        runs[0] = '{lim: 4'd0,  img: 64'h0000_0000_0000_000A, ini_cyc: 0,  lim_cyc: 0};
        runs[1] = '{lim: 4'd3,  img: 64'h0000_0000_0000_8421, ini_cyc: 0,  lim_cyc: 0};
        runs[2] = '{lim: 4'd15, img: 64'hFEDC_BA98_7654_3210, ini_cyc: 0,  lim_cyc: 0};
        runs[3] = '{lim: 4'd3,  img: 64'h0000_0000_0000_8421, ini_cyc: 10, lim_cyc: 12};

        reset   = 1'b1;
        iniciar = 1'b0;
        limite  = 4'd0;
        load_rom(64'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_estado", 0, db_estado, 4'd0);
        check("rst_leds", 0, leds, 4'd0);
        check("rst_endereco", 0, endereco, 4'd0);
        check("rst_ocupado", 0, {3'b0, ocupado}, 4'd0);
        check("rst_pronto", 0, {3'b0, pronto}, 4'd0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) do_run(runs[i]);

        // Reset asserted in the middle of the second word's LIGA phase.
        load_rom(runs[1].img);
        start(4'd3);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clock);
            expect_cycle(c, 3, runs[1].img);
        end
        @(posedge clock);
        #1;
        check("pre_rst_leds", 12, leds, 4'd2);
        reset = 1'b1;
        #1;
        check("mid_rst_leds", 12, leds, 4'd0);
        check("mid_rst_endereco", 12, endereco, 4'd0);
        check("mid_rst_ocupado", 12, {3'b0, ocupado}, 4'd0);
        check("mid_rst_estado", 12, db_estado, 4'd0);
        check("mid_rst_pronto", 12, {3'b0, pronto}, 4'd0);
        for (int c = 13; c <= 15; c++) begin
            @(negedge clock);
            check("rst_hold_pronto", c, {3'b0, pronto}, 4'd0);
            check("rst_hold_estado", c, db_estado, 4'd0);
        end
        reset = 1'b0;
        for (int c = 16; c <= 18; c++) begin
            @(negedge clock);
            check("idle_pronto", c, {3'b0, pronto}, 4'd0);
            check("idle_estado", c, db_estado, 4'd0);
        end
        do_run(runs[1]);

        // iniciar held high: back-to-back single-word runs, pronto every 10 cycles.
        load_rom(runs[0].img);
        @(negedge clock);
        limite  = 4'd0;
        iniciar = 1'b1;
        @(posedge clock);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            expect_cycle(((c - 1) % 10) + 1, 0, runs[0].img);
        end
        iniciar = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
